// File: rtl/sqrt_fp_postproc.sv
// Post-processing stage of the bfloat16 sqrt / inverse-sqrt unit: classify, normalize, round, pack.
// Define SQRT_WATCHDOG_EN to bound the wait for the mantissa core with a watchdog.
module sqrt_fp_postproc #(
    parameter int FLOAT_DW  = 16,
    parameter int E_DW      = 8,
    parameter int F_DW      = 7,
    parameter int BIAS      = 127,
    parameter int WD_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_i,
    input  logic                  op_inv_i,
    input  logic [FLOAT_DW-1:0]   op_i,
    input  logic                  core_valid_i,
    input  logic [2*(F_DW+1)-1:0] core_result_i,
    output logic [FLOAT_DW-1:0]   res_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic                  invalid_o,
    output logic                  divzero_o,
    output logic                  timeout_o,
    output logic                  busy_o
);
    localparam int CW = 2 * (F_DW + 1);
    localparam int RW = CW - F_DW - 1;
    localparam int XW = E_DW + 2;
    localparam logic signed [XW-1:0] BIAS_X   = XW'(BIAS);
    localparam logic signed [XW-1:0] ONE_X    = XW'(1);
    localparam logic [RW-1:0]        HALF     = {1'b1, {(RW-1){1'b0}}};
    localparam logic [FLOAT_DW-2:0]  INF_MAG  = {{E_DW{1'b1}}, {F_DW{1'b0}}};
    localparam logic [FLOAT_DW-1:0]  QNAN     = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_NORM, S_OUT} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        core_q, core_d;
    logic signed [XW-1:0] exp_q, exp_d;
    logic [FLOAT_DW-1:0]  res_q, res_d;
    logic                 invalid_q, invalid_d;
    logic                 divzero_q, divzero_d;

    // Operand classification and base exponent, evaluated on the live operand
    logic                 op_sign;
    logic [E_DW-1:0]      op_exp;
    logic [F_DW-1:0]      op_frac;
    logic                 is_nan, is_zero, is_inf;
    logic signed [XW-1:0] e_unb, k_half, exp_issue;

    always_comb begin
        op_sign   = op_i[FLOAT_DW-1];
        op_exp    = op_i[FLOAT_DW-2 -: E_DW];
        op_frac   = op_i[F_DW-1:0];
        is_nan    = (&op_exp) && (|op_frac);
        is_zero   = (op_exp == '0);
        is_inf    = (&op_exp) && (op_frac == '0);
        e_unb     = $signed({2'b00, op_exp}) - BIAS_X;
        // (E+1)>>>1 is E/2 for even E and (E+1)/2 for odd E
        k_half    = (e_unb + ONE_X) >>> 1;
        exp_issue = op_inv_i ? (BIAS_X - k_half) : (BIAS_X + k_half);
    end

    logic                 norm_hi, rnd_up;
    logic [F_DW-1:0]      frac_sel;
    logic [RW-1:0]        rnd_bits;
    logic [F_DW:0]        frac_sum;
    logic signed [XW-1:0] exp_adj, carry_x;
    logic [E_DW-1:0]      exp_out;

    always_comb begin
        norm_hi  = core_q[CW-1];
        frac_sel = norm_hi ? core_q[CW-2 -: F_DW] : core_q[CW-3 -: F_DW];
        // Low path has one fewer round bit; pad so both compare against the same half
        rnd_bits = norm_hi ? core_q[RW-1:0] : {core_q[RW-2:0], 1'b0};
        rnd_up   = (rnd_bits > HALF) || ((rnd_bits == HALF) && frac_sel[0]);
        frac_sum = {1'b0, frac_sel} + {{F_DW{1'b0}}, rnd_up};
        exp_adj  = norm_hi ? '0 : '1;
        carry_x  = $signed({{(XW-1){1'b0}}, frac_sum[F_DW]});
        exp_out  = E_DW'(exp_q + exp_adj + carry_x);
    end

`ifdef SQRT_WATCHDOG_EN
    logic [3:0] wd_q, wd_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        core_d    = core_q;
        exp_d     = exp_q;
        res_d     = res_q;
        invalid_d = invalid_q;
        divzero_d = divzero_q;
`ifdef SQRT_WATCHDOG_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (issue_i) begin
                    exp_d     = exp_issue;
                    invalid_d = 1'b0;
                    divzero_d = 1'b0;
`ifdef SQRT_WATCHDOG_EN
                    timeout_d = 1'b0;
                    wd_d      = '0;
`endif
                    state_d   = S_OUT;
                    if (is_nan || (op_sign && !is_zero)) begin
                        res_d     = QNAN;
                        invalid_d = 1'b1;
                    end else if (is_zero) begin
                        res_d     = op_inv_i ? {op_sign, INF_MAG} : {op_sign, {(FLOAT_DW-1){1'b0}}};
                        divzero_d = op_inv_i;
                    end else if (is_inf) begin
                        res_d     = op_inv_i ? '0 : {1'b0, INF_MAG};
                    end else begin
                        state_d   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (core_valid_i) begin
                    core_d  = core_result_i;
                    state_d = S_NORM;
`ifdef SQRT_WATCHDOG_EN
                end else if (wd_q == 4'(WD_CYCLES - 1)) begin
                    res_d     = QNAN;
                    invalid_d = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_OUT;
                end else begin
                    wd_d = wd_q + 4'd1;
`endif
                end
            end
            S_NORM: begin
                // On fraction carry-out the low fraction bits are already zero
                res_d   = {1'b0, exp_out, frac_sum[F_DW-1:0]};
                state_d = S_OUT;
            end
            S_OUT: begin
                if (res_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            core_q    <= '0;
            exp_q     <= '0;
            res_q     <= '0;
            invalid_q <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            core_q    <= core_d;
            exp_q     <= exp_d;
            res_q     <= res_d;
            invalid_q <= invalid_d;
            divzero_q <= divzero_d;
        end
    end

`ifdef SQRT_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign res_o       = res_q;
    assign res_valid_o = (state_q == S_OUT);
    assign invalid_o   = invalid_q;
    assign divzero_o   = divzero_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sqrt_fp_postproc.sv
// Directed scoreboard bench for sqrt_fp_postproc; expected results are hand-computed bfloat16 values.
module tb_sqrt_fp_postproc;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_i;
    logic        op_inv_i;
    logic [15:0] op_i;
    logic        core_valid_i;
    logic [15:0] core_result_i;
    logic [15:0] res_o;
    logic        res_valid_o;
    logic        res_ready_i;
    logic        invalid_o;
    logic        divzero_o;
    logic        timeout_o;
    logic        busy_o;

    sqrt_fp_postproc dut (
        .clk           (clk),
        .rst           (rst),
        .issue_i       (issue_i),
        .op_inv_i      (op_inv_i),
        .op_i          (op_i),
        .core_valid_i  (core_valid_i),
        .core_result_i (core_result_i),
        .res_o         (res_o),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .invalid_o     (invalid_o),
        .divzero_o     (divzero_o),
        .timeout_o     (timeout_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        inv;
        logic        dz;
        logic        to;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [15:0] r, input logic i, input logic d, input logic t);
        exp_t e;
        e.res = r;
        e.inv = i;
        e.dz  = d;
        e.to  = t;
        sb_q.push_back(e);
        nm_q.push_back(name);
    endtask

    // Monitor: every accepted result is checked against the oldest expectation
    always @(negedge clk) begin
        if (!rst && res_valid_o && res_ready_i) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got res=%h, expected no result", res_o);
            end else begin
                exp_t  e;
                exp_t  a;
                string nm;
                e  = sb_q.pop_front();
                nm = nm_q.pop_front();
                a  = {res_o, invalid_o, divzero_o, timeout_o};
                $display("txn %s res=%h inv=%b dz=%b to=%b", nm, res_o, invalid_o, divzero_o, timeout_o);
                chk(nm, 32'(a), 32'(e));
            end
        end
    end

    task automatic run_normal(input string name, input logic [15:0] op, input logic inv,
                              input logic [15:0] core, input int dly, input logic [15:0] res);
        step();
        issue_i  = 1'b1;
        op_i     = op;
        op_inv_i = inv;
        push(name, res, 1'b0, 1'b0, 1'b0);
        step();
        issue_i = 1'b0;
        @(negedge clk);
        chk({name, "_busy"}, 32'(busy_o), 32'd1);
        repeat (dly - 1) step();
        core_valid_i  = 1'b1;
        core_result_i = core;
        step();
        core_valid_i = 1'b0;
        @(negedge clk);
        chk({name, "_lat1"}, 32'(res_valid_o), 32'd0);
        step();
        @(negedge clk);
        chk({name, "_lat2"}, 32'(res_valid_o), 32'd1);
        step();
    endtask

    task automatic run_special(input string name, input logic [15:0] op, input logic inv,
                               input logic [15:0] res, input logic i, input logic d);
        step();
        issue_i  = 1'b1;
        op_i     = op;
        op_inv_i = inv;
        push(name, res, i, d, 1'b0);
        step();
        issue_i = 1'b0;
        @(negedge clk);
        chk({name, "_lat"}, 32'(res_valid_o), 32'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        issue_i       = 1'b0;
        op_inv_i      = 1'b0;
        op_i          = '0;
        core_valid_i  = 1'b0;
        core_result_i = '0;
        res_ready_i   = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("reset_state", 32'({res_o, res_valid_o, invalid_o, divzero_o, timeout_o, busy_o}), 32'd0);
        step();
        rst = 1'b0;

        // Normal path
        run_normal("sqrt_4",      16'h4080, 1'b0, 16'h8000, 3, 16'h4000);
        run_normal("isqrt_4",     16'h4080, 1'b1, 16'h8000, 3, 16'h3F00);
        run_normal("sqrt_2",      16'h4000, 1'b0, 16'h5A82, 3, 16'h3FB5);
        run_normal("sqrt_carry",  16'h4080, 1'b0, 16'hFFFF, 3, 16'h4080);
        run_normal("sqrt_1",      16'h3F80, 1'b0, 16'h8000, 1, 16'h3F80);
        run_normal("isqrt_2",     16'h4000, 1'b1, 16'hB505, 2, 16'h3F35);
        run_normal("tie_hi_even", 16'h4080, 1'b0, 16'h8080, 3, 16'h4000);
        run_normal("tie_hi_odd",  16'h4080, 1'b0, 16'h8180, 3, 16'h4002);
        run_normal("tie_lo_even", 16'h4000, 1'b0, 16'h4040, 3, 16'h3F80);
        run_normal("tie_lo_odd",  16'h4000, 1'b0, 16'h40C0, 3, 16'h3F82);
        run_normal("lo_above",    16'h4000, 1'b0, 16'h4041, 3, 16'h3F81);
        run_normal("sqrt_tiny_e", 16'h0080, 1'b0, 16'h8000, 3, 16'h2000);
        run_normal("isqrt_tiny",  16'h0080, 1'b1, 16'h8000, 3, 16'h5F00);
        run_normal("sqrt_tiny_o", 16'h0100, 1'b0, 16'h8000, 3, 16'h2080);

        // Special operands
        run_special("neg_sqrt",    16'hC080, 1'b0, 16'h7FC0, 1'b1, 1'b0);
        run_special("zero_isqrt",  16'h0000, 1'b1, 16'h7F80, 1'b0, 1'b1);
        run_special("nzero_sqrt",  16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0);
        run_special("inf_isqrt",   16'h7F80, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_special("inf_sqrt",    16'h7F80, 1'b0, 16'h7F80, 1'b0, 1'b0);
        run_special("ninf_sqrt",   16'hFF80, 1'b0, 16'h7FC0, 1'b1, 1'b0);
        run_special("nan_isqrt",   16'h7FC1, 1'b1, 16'h7FC0, 1'b1, 1'b0);
        run_special("nzero_isqrt", 16'h8000, 1'b1, 16'hFF80, 1'b0, 1'b1);
        run_special("subn_sqrt",   16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Backpressure: output held, stray issue and core pulses ignored
        step();
        res_ready_i = 1'b0;
        issue_i     = 1'b1;
        op_i        = 16'h7F80;
        op_inv_i    = 1'b0;
        push("bp_inf", 16'h7F80, 1'b0, 1'b0, 1'b0);
        step();
        issue_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", 32'({res_o, res_valid_o, busy_o, invalid_o}), 32'({16'h7F80, 1'b1, 1'b1, 1'b0}));
            step();
            if (i == 1) begin
                issue_i  = 1'b1;
                op_i     = 16'hC080;
                op_inv_i = 1'b1;
            end else begin
                issue_i = 1'b0;
            end
            if (i == 2) begin
                core_valid_i  = 1'b1;
                core_result_i = 16'hFFFF;
            end else begin
                core_valid_i = 1'b0;
            end
        end
        issue_i      = 1'b0;
        core_valid_i = 1'b0;
        res_ready_i  = 1'b1;
        step();
        @(negedge clk);
        chk("bp_idle", 32'({busy_o, res_valid_o}), 32'd0);
        run_special("bp_next", 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0);

        // Reset in WAIT discards the operation
        step();
        issue_i  = 1'b1;
        op_i     = 16'h4080;
        op_inv_i = 1'b0;
        step();
        issue_i = 1'b0;
        @(negedge clk);
        chk("rst_pre_busy", 32'(busy_o), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs", 32'({res_o, res_valid_o, invalid_o, divzero_o, timeout_o, busy_o}), 32'd0);
        core_valid_i  = 1'b1;
        core_result_i = 16'h8000;
        step();
        core_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ignore_core", 32'({res_valid_o, busy_o}), 32'd0);
            step();
        end

`ifdef SQRT_WATCHDOG_EN
        step();
        issue_i  = 1'b1;
        op_i     = 16'h4080;
        op_inv_i = 1'b0;
        push("wd_timeout", 16'h7FC0, 1'b1, 1'b0, 1'b1);
        step();
        issue_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("wd_wait", 32'(res_valid_o), 32'd0);
            step();
        end
        @(negedge clk);
        chk("wd_fire", 32'(res_valid_o), 32'd1);
        step();
        core_valid_i  = 1'b1;
        core_result_i = 16'h8000;
        step();
        core_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wd_late_core", 32'({res_valid_o, busy_o}), 32'd0);
            step();
        end
`else
        run_normal("sqrt_4_slow", 16'h4080, 1'b0, 16'h8000, 25, 16'h4000);
`endif

        repeat (3) step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sqrt_fp_postproc.md
Name: sqrt_fp_postproc

Overview:
- Downstream stage of the iterative mantissa square-root core, inside the bfloat16 sqrt / inverse-sqrt unit.
- Captures the original operand when the top issues an operation, classifies it and derives the result exponent.
- Waits for the core's raw Q1.15 result, then normalizes, rounds to nearest-even and packs the 16-bit result [s|e|m] = [1|8|7].
- Special operands bypass the core; the result is delivered through a valid/ready output handshake.

Parameters:
- FLOAT_DW, 16: packed float width.
- E_DW, 8: exponent width.
- F_DW, 7: fraction width. The core result width is 2*(F_DW+1).
- BIAS, 127: exponent bias.
- WD_CYCLES, 15: watchdog limit in cycles. Used only with SQRT_WATCHDOG_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- issue_i  in  1  one-cycle pulse; operation issued. Sampled only in IDLE.
- op_inv_i  in  1  0 = sqrt, 1 = inverse sqrt. Sampled with issue_i.
- op_i  in  FLOAT_DW  original packed operand. Sampled with issue_i.
- core_valid_i  in  1  core result valid pulse
- core_result_i  in  2*(F_DW+1)  core result, Q1.15 unsigned
- res_o  out  FLOAT_DW  packed result
- res_valid_o  out  1  result valid
- res_ready_i  in  1  consumer ready
- invalid_o  out  1  invalid-operation flag. Qualified by res_valid_o.
- divzero_o  out  1  divide-by-zero flag. Qualified by res_valid_o.
- timeout_o  out  1  watchdog flag. Qualified by res_valid_o.
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: res_o=0, res_valid_o=0, all flags 0, busy_o=0, state IDLE. Reset mid-operation discards the in-flight operation with no output.
- States: IDLE, WAIT, NORM, OUT.
- IDLE:
  - On issue_i, register op_i, op_inv_i and the classification.
  - Special operand: go to OUT; res_valid_o is high on cycle issue+1.
  - Otherwise: go to WAIT.
- WAIT: stay until core_valid_i. On core_valid_i, register core_result_i and go to NORM.
- NORM: one cycle of normalize, round and pack into output registers, then go to OUT.
  - Normal-path latency: res_valid_o is high 2 cycles after the core_valid_i cycle.
- OUT:
  - res_valid_o=1; res_o and all flags held stable.
  - On res_ready_i=1, go to IDLE on the next cycle. Ready is allowed to be high in the same cycle valid rises.
- issue_i outside IDLE is ignored; the upstream must check busy_o.
- core_valid_i outside WAIT is ignored.
- Operand classification, with E = e - BIAS:
  - NaN, or negative nonzero: 0x7FC0, invalid_o=1.
  - e=0 (zero or subnormal, flushed to zero):
    - sqrt: signed zero, i.e. sign bit followed by 0x000.
    - invsqrt: signed infinity, sign|0x7F80, divzero_o=1.
  - +inf: sqrt gives 0x7F80; invsqrt gives 0x0000.
- Exponent for normal operands, computed in signed E_DW+2 bits:
  - Even E: core operand is 1.M; k = E/2.
  - Odd E: core operand is 0.1M; k = (E+1)/2.
  - Base result exponent: BIAS+k for sqrt, BIAS-k for invsqrt.
- Normalize:
  - core_result_i[15]=1: fraction = [14:8], round bits = [7:0], exponent unchanged.
  - Otherwise: fraction = [13:7], round bits = [6:0], exponent-1.
- Round to nearest, ties to even: round up if the round bits exceed half, or equal half and the fraction LSB is 1.
  - A fraction carry-out sets fraction=0 and exponent+1.
- Sign of a normal result is always 0. Exponent overflow/underflow is unreachable for normal operands.

Optional Feature:
- SQRT_WATCHDOG_EN defined:
  - A 4-bit counter clears on WAIT entry and increments each WAIT cycle.
  - On reaching WD_CYCLES without core_valid_i: go to OUT with res_o=0x7FC0, timeout_o=1, invalid_o=1.
  - A core_valid_i arriving later is ignored.
- SQRT_WATCHDOG_EN undefined: WAIT is unbounded and timeout_o is tied to 0.

Test Plan:
- sqrt issue op_i=0x4080 (4.0), core_result_i=0x8000 three cycles later -> res_o=0x4000, flags 0, res_valid_o 2 cycles after core_valid_i.
- invsqrt op_i=0x4080, core_result_i=0x8000 -> res_o=0x3F00 (0.5).
- sqrt op_i=0x4000 (2.0, odd exponent), core_result_i=0x5A82 -> res_o=0x3FB5.
- Rounding carry: sqrt op_i=0x4080, core_result_i=0xFFFF -> res_o=0x4080.
- Specials, each with res_valid_o at issue+1 and no core_valid_i:
  - 0xC080 sqrt -> 0x7FC0, invalid_o=1.
  - 0x0000 invsqrt -> 0x7F80, divzero_o=1.
  - 0x8000 sqrt -> 0x8000.
  - 0x7F80 invsqrt -> 0x0000.
- Backpressure and reset:
  - Hold res_ready_i=0 for 5 cycles -> res_o stable, busy_o=1, issue_i ignored. Ready=1 -> IDLE next cycle, and a new issue is accepted.
  - rst asserted in WAIT -> all outputs 0; a following core_valid_i is ignored.
  - With SQRT_WATCHDOG_EN: no core_valid_i for 15 cycles -> 0x7FC0, timeout_o=1.
